// File: rtl/lap_timer.sv
// Single-clock race lap timer: centisecond lap clock, finish-line edge detection,
// last/best lap capture and lap counting through an IDLE/RUNNING/DONE FSM.
module lap_timer #(
    parameter int CLK_HZ     = 65_000_000,
    parameter int NUM_LAPS   = 3,
    parameter int MIN_LAP_CS = 200,
    parameter int MAX_CS     = 59999
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        race_start,
    input  logic        finish_line,
    output logic [15:0] current_lap_time,
    output logic [15:0] last_lap_time,
    output logic [15:0] best_lap_time,
    output logic [3:0]  lap_count,
    output logic        lap_valid,
    output logic        race_done
);

    localparam int PRESCALE = CLK_HZ / 100;
    localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [15:0]     MIN_TIME = 16'(MIN_LAP_CS);
    localparam logic [15:0]     MAX_TIME = 16'(MAX_CS);
    localparam logic [3:0]      LAPS     = 4'(NUM_LAPS);

    typedef enum logic [1:0] {IDLE, RUNNING, DONE} state_t;

    state_t          state, state_next;
    logic [PS_W-1:0] prescaler, prescaler_d;
    logic [15:0]     cur_d, last_d, best_d;
    logic [3:0]      count_d;
    logic            valid_d, done_d;
    logic            fl_prev;
    logic            crossing, cs_tick, lap_ok, final_lap;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case/if tree can leave it unassigned and infer a latch.
    always_comb begin
        crossing  = finish_line & ~fl_prev;
        cs_tick   = (state == RUNNING) && (prescaler == PS_LAST);
        lap_ok    = (state == RUNNING) && crossing && (current_lap_time >= MIN_TIME);
        final_lap = lap_ok && ((lap_count + 4'd1) == LAPS);

        state_next  = state;
        prescaler_d = prescaler;
        cur_d       = current_lap_time;
        last_d      = last_lap_time;
        best_d      = best_lap_time;
        count_d     = lap_count;
        valid_d     = 1'b0;
        done_d      = race_done;

        if (race_start) begin
            // A restart wins over any crossing seen in the same cycle.
            state_next  = RUNNING;
            prescaler_d = '0;
            cur_d       = '0;
            last_d      = '0;
            best_d      = '0;
            count_d     = '0;
            done_d      = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    prescaler_d = '0;
                    cur_d       = '0;
                end
                RUNNING: begin
                    if (lap_ok) begin
                        // Capture the pre-increment time; a coincident tick is dropped.
                        last_d      = current_lap_time;
                        cur_d       = '0;
                        prescaler_d = '0;
                        count_d     = lap_count + 4'd1;
                        valid_d     = 1'b1;
                        if (lap_count == 4'd0 || current_lap_time < best_lap_time)
                            best_d = current_lap_time;
                        if (final_lap) begin
                            state_next = DONE;
                            done_d     = 1'b1;
                        end
                    end else if (cs_tick) begin
                        prescaler_d = '0;
                        if (current_lap_time < MAX_TIME)
                            cur_d = current_lap_time + 16'd1;
                    end else begin
                        prescaler_d = prescaler + 1'b1;
                    end
                end
                DONE: begin
                    prescaler_d = '0;
                    cur_d       = '0;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed above.
    // NOTE: the idle line sample resets to 1, so a car sitting on the line when
    // reset releases is not mistaken for a crossing.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            prescaler        <= '0;
            current_lap_time <= '0;
            last_lap_time    <= '0;
            best_lap_time    <= '0;
            lap_count        <= '0;
            lap_valid        <= 1'b0;
            race_done        <= 1'b0;
            fl_prev          <= 1'b1;
        end else begin
            state            <= state_next;
            prescaler        <= prescaler_d;
            current_lap_time <= cur_d;
            last_lap_time    <= last_d;
            best_lap_time    <= best_d;
            lap_count        <= count_d;
            lap_valid        <= valid_d;
            race_done        <= done_d;
            fl_prev          <= finish_line;
        end
    end

endmodule

// File: doc/lap_timer.md
LAP_TIMER -- requirements
Module: lap_timer

Interface
REQ-001 Parameter CLK_HZ, default 65_000_000, pclk frequency in Hz; the centisecond prescale period is CLK_HZ/100 cycles.
REQ-002 Parameter NUM_LAPS, default 3, number of laps per race (1..15).
REQ-003 Parameter MIN_LAP_CS, default 200, minimum lap duration in centiseconds for a finish-line crossing to count.
REQ-004 Parameter MAX_CS, default 59999, saturation value of every time output (9:59.99).
REQ-005 pclk  input  1  system clock; the block SHALL use this single clock only.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 race_start  input  1  single-cycle pulse that starts or restarts a race.
REQ-008 finish_line  input  1  level, high while the car overlaps the finish line; synchronous to pclk.
REQ-009 current_lap_time  output  16  running lap time, binary centiseconds.
REQ-010 last_lap_time  output  16  time of the most recently completed lap, binary centiseconds; drives the time-to-character display stage.
REQ-011 best_lap_time  output  16  fastest completed lap of the current race, binary centiseconds.
REQ-012 lap_count  output  4  number of completed laps.
REQ-013 lap_valid  output  1  single-cycle pulse marking each counted lap.
REQ-014 race_done  output  1  high once NUM_LAPS laps have been completed.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUNNING, DONE; all outputs SHALL be registered.
REQ-016 A race_start pulse in any state SHALL, on the next edge, enter RUNNING and clear the prescaler, current_lap_time, last_lap_time, best_lap_time, lap_count, and race_done to 0.
REQ-017 race_start SHALL take priority over a crossing in the same cycle.
REQ-018 In RUNNING, the prescaler SHALL count 0..CLK_HZ/100-1 and generate an internal cs_tick when it reaches the terminal value, then wrap to 0.
REQ-019 On cs_tick, current_lap_time SHALL increment by 1 and saturate at MAX_CS without wrapping.
REQ-020 A crossing SHALL be a rising edge of finish_line, detected against a registered previous sample that is reset to 1.
REQ-021 A crossing in RUNNING with current_lap_time >= MIN_LAP_CS SHALL be valid; a crossing in RUNNING below that threshold, and any crossing in IDLE or DONE, SHALL be ignored.
REQ-022 On a valid crossing, the following SHALL all occur on the same edge:
 - last_lap_time <= current_lap_time, the pre-increment value; a coincident cs_tick is discarded.
 - current_lap_time <= 0 and prescaler <= 0.
 - lap_count <= lap_count+1.
 - lap_valid = 1 for exactly one cycle.
 - best_lap_time <= current_lap_time if lap_count was 0 or current_lap_time < best_lap_time; an equal time leaves best_lap_time unchanged.
REQ-023 When a valid crossing makes lap_count equal NUM_LAPS, the FSM SHALL go to DONE and race_done SHALL rise on that same edge.
REQ-024 In DONE, the prescaler and current_lap_time SHALL freeze at 0, and every other output SHALL hold until race_start or rst.
REQ-025 In IDLE, the prescaler and all time outputs SHALL hold at 0.
REQ-026 A single crossing SHALL count at most once, regardless of how long finish_line stays high.

Reset
REQ-027 On rst assertion, the following SHALL take effect immediately (asynchronously): FSM <= IDLE; prescaler, current_lap_time, last_lap_time, best_lap_time, lap_count, lap_valid, race_done <= 0; previous finish_line sample <= 1.
REQ-028 Reset asserted mid-race SHALL abandon the race; after deassertion the block SHALL stay in IDLE until race_start.

Verification (CLK_HZ=1000 giving 10 cycles/cs, MIN_LAP_CS=5, NUM_LAPS=3)
REQ-029 Basic lap: race_start, 120 cycles, then a finish_line pulse.
 - current_lap_time SHALL read 12 before the edge.
 - Then last_lap_time=12, best_lap_time=12, lap_count=1, one lap_valid pulse, current_lap_time=0.
REQ-030 Early crossing: after a lap, a crossing at current_lap_time=3 SHALL change nothing; a later crossing at 8 SHALL give last=8, best=8, lap_count=2.
REQ-031 Full race: laps of 12, 8, 20 -> lap_count=3, race_done=1, last=20, best=8.
 - In DONE, additional finish_line pulses and 1000 idle cycles SHALL change no output.
REQ-032 Held line and saturation:
 - finish_line held high for 200 cycles SHALL produce exactly one lap_valid.
 - Running 600 000 cycles without crossing SHALL saturate current_lap_time at 59999.
REQ-033 Priority and reset:
 - race_start coincident with a valid crossing SHALL restart the race with lap_count=0 and no lap_valid.
 - rst pulsed mid-race SHALL zero all outputs immediately.
